// File: rtl/ram_controller_pkg.sv
// Shared types and constants for the word-addressed RAM controller.
package ram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    localparam int          DEFAULT_DEPTH   = 256;
    localparam int          DEFAULT_LATENCY = 2;
    localparam logic [31:0] POISON          = 32'hDEADBEEF;

endpackage

// File: rtl/ram_array.sv
// Word storage: two synchronous write ports and one combinational read port.
module ram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_idx,
    input  logic [31:0]   ld_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Loader is assigned last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
        if (ld_en) mem[ld_idx] <= ld_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ram_controller.sv
// Request FSM with fixed-latency ack, sticky error flags and loader port.
module ram_controller
    import ram_controller_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rd_ack,
    output logic        wr_ack,
    input  logic        ld_en,
    input  logic [7:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        busy,
    output logic        addr_err,
    output logic        proto_err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [29:0] word_q;
    logic [31:0] wdata_q;
    logic        is_rd_q;
    logic        commit, req, in_range, ld_ok, wr_en;
    logic [31:0] word, ld_word, mem_rdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];
    assign req      = rd_req | wr_req;
    assign word     = {2'b00, word_q};
    assign ld_word  = {24'd0, ld_addr};
    assign in_range = word < 32'(DEPTH);
    assign ld_ok    = ld_en && (ld_word < 32'(DEPTH));
    assign wr_en    = commit && !is_rd_q && in_range;

    assign busy   = (state != IDLE);
    assign rd_ack = (state == ACK) && is_rd_q;
    assign wr_ack = (state == ACK) && !is_rd_q;

    // Every request passes through WAIT, so the ack lands LATENCY
    // edges after sampling even when LATENCY is 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ACK;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            word_q    <= '0;
            wdata_q   <= '0;
            is_rd_q   <= 1'b0;
            rdata     <= '0;
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) begin
                word_q  <= addr[31:2];
                wdata_q <= wdata;
                is_rd_q <= rd_req;
            end
            if (state == IDLE && rd_req && wr_req) proto_err <= 1'b1;
            if (state != IDLE && req) proto_err <= 1'b1;
            if (commit) begin
                if (!in_range) addr_err <= 1'b1;
                if (is_rd_q) rdata <= in_range ? mem_rdata : POISON;
            end
        end
    end

    ram_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (word[AW-1:0]),
        .wr_data(wdata_q),
        .ld_en  (ld_ok),
        .ld_idx (ld_word[AW-1:0]),
        .ld_data(ld_data),
        .rd_idx (word[AW-1:0]),
        .rd_data(mem_rdata)
    );

endmodule

// File: tb/tb_ram_controller.sv
// Self-checking bench: directed vector table plus randomized model comparison.
module tb_ram_controller;

    localparam int          DEPTH = 256;
    localparam logic [31:0] DEAD  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req, wr_req, ld_en;
    logic [31:0] addr, wdata, ld_data;
    logic [7:0]  ld_addr;

    logic [31:0] rdata_a, rdata_b;
    logic        rd_ack_a, wr_ack_a, busy_a, aerr_a, perr_a;
    logic        rd_ack_b, wr_ack_b, busy_b, aerr_b, perr_b;

    logic        sel;
    int          lat;
    logic [31:0] rdata;
    logic        rd_ack, wr_ack, busy, addr_err, proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_controller #(.DEPTH(DEPTH), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .wr_req(wr_req),
        .addr(addr), .wdata(wdata), .rdata(rdata_a),
        .rd_ack(rd_ack_a), .wr_ack(wr_ack_a),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy_a), .addr_err(aerr_a), .proto_err(perr_a)
    );

    ram_controller #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .wr_req(wr_req),
        .addr(addr), .wdata(wdata), .rdata(rdata_b),
        .rd_ack(rd_ack_b), .wr_ack(wr_ack_b),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy_b), .addr_err(aerr_b), .proto_err(perr_b)
    );

    always_comb begin
        rdata     = sel ? rdata_b  : rdata_a;
        rd_ack    = sel ? rd_ack_b : rd_ack_a;
        wr_ack    = sel ? wr_ack_b : wr_ack_a;
        busy      = sel ? busy_b   : busy_a;
        addr_err  = sel ? aerr_b   : aerr_a;
        proto_err = sel ? perr_b   : perr_a;
    end

    typedef struct {
        string       name;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          ld_at;
        logic [7:0]  la;
        logic [31:0] ldd;
        int          inj_at;
        logic [31:0] rdata;
        logic [1:0]  kind;
        logic        aerr;
        logic        perr;
    } vec_t;

    function automatic vec_t mk(
        string n, logic r, logic w, logic [31:0] a, logic [31:0] d,
        int ld_at, logic [7:0] la, logic [31:0] ldd, int inj_at,
        logic [31:0] rd, logic [1:0] kind, logic aerr, logic perr);
        vec_t v;
        v.name = n; v.r = r; v.w = w; v.a = a; v.d = d;
        v.ld_at = ld_at; v.la = la; v.ldd = ldd; v.inj_at = inj_at;
        v.rdata = rd; v.kind = kind; v.aerr = aerr; v.perr = perr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/rdata"}, rdata, 32'h0);
        check({tag, "/acks"}, 32'({rd_ack, wr_ack}), 32'h0);
        check({tag, "/busy"}, 32'(busy), 32'h0);
        check({tag, "/flags"}, 32'({addr_err, proto_err}), 32'h0);
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] val);
        ld_en = 1'b1; ld_addr = idx; ld_data = val;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Called at the start of a cycle; the request is sampled at the next
    // edge (E0). Cycle c is the cycle that begins at edge Ec.
    task automatic xact(
        input logic r, input logic w, input logic [31:0] a,
        input logic [31:0] d, input int ld_at, input logic [7:0] la,
        input logic [31:0] ldd, input int inj_at, input int tail,
        output int acks, output int ack_c, output logic [1:0] kind,
        output logic ack_busy, output logic pre_ok);
        rd_req = r; wr_req = w; addr = a; wdata = d;
        @(negedge clk);
        pre_ok = !busy && !rd_ack && !wr_ack;
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0;
        addr = $urandom; wdata = $urandom;
        acks = 0; ack_c = -1; kind = 2'b00; ack_busy = 1'b0;
        for (int c = 0; c < lat + 1 + tail; c++) begin
            ld_en = (c == ld_at); ld_addr = la; ld_data = ldd;
            rd_req = (c == inj_at);
            @(negedge clk);
            if (rd_ack || wr_ack) begin
                acks++;
                if (ack_c < 0) begin
                    ack_c = c; kind = {rd_ack, wr_ack}; ack_busy = busy;
                end
            end
            @(posedge clk); #1;
        end
        ld_en = 1'b0; rd_req = 1'b0;
    endtask

    vec_t        tbl[$];
    logic [31:0] mm [DEPTH];
    logic [31:0] m_rdata;
    logic        m_aerr, m_perr;

    initial begin
        int          acks, ack_c, n;
        logic [1:0]  kind;
        logic        ack_busy, pre_ok;
        sel = 1'b0; lat = 2;
        reset = 1'b1;
        rd_req = 0; wr_req = 0; ld_en = 0;
        addr = 0; wdata = 0; ld_addr = 0; ld_data = 0;
        #12;
        check_reset_vals("reset");
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;

        load(8'd3, 32'h12345678);
        load(8'd4, 32'h11111111);
        load(8'd5, 32'h55555555);
        load(8'd6, 32'h66666666);
        load(8'd8, 32'h88888888);

        tbl.push_back(mk("rd_w3", 1, 0, 32'h0C, 0, -1, 0, 0, -1,
                         32'h12345678, 2'b10, 0, 0));
        tbl.push_back(mk("rd_w4_old", 1, 0, 32'h10, 0, -1, 0, 0, -1,
                         32'h11111111, 2'b10, 0, 0));
        tbl.push_back(mk("wr_w4", 0, 1, 32'h10, 32'hCAFEF00D, -1, 0, 0, -1,
                         32'h11111111, 2'b01, 0, 0));
        tbl.push_back(mk("rd_w4_new", 1, 0, 32'h13, 0, -1, 0, 0, -1,
                         32'hCAFEF00D, 2'b10, 0, 0));
        tbl.push_back(mk("wr_ld_win", 0, 1, 32'h14, 32'hAAAAAAAA, 1, 5,
                         32'hBBBBBBBB, -1, 32'hCAFEF00D, 2'b01, 0, 0));
        tbl.push_back(mk("rd_w5", 1, 0, 32'h14, 0, -1, 0, 0, -1,
                         32'hBBBBBBBB, 2'b10, 0, 0));
        tbl.push_back(mk("rd_ld_same", 1, 0, 32'h18, 0, 1, 6,
                         32'h77777777, -1, 32'h66666666, 2'b10, 0, 0));
        tbl.push_back(mk("rd_w6_new", 1, 0, 32'h18, 0, -1, 0, 0, -1,
                         32'h77777777, 2'b10, 0, 0));
        tbl.push_back(mk("rd_oor", 1, 0, 32'h400, 0, -1, 0, 0, -1,
                         DEAD, 2'b10, 1, 0));
        tbl.push_back(mk("wr_oor", 0, 1, 32'h404, 0, -1, 0, 0, -1,
                         DEAD, 2'b01, 1, 0));
        tbl.push_back(mk("both_inj", 1, 1, 32'h0C, 0, -1, 0, 0, 1,
                         32'h12345678, 2'b10, 1, 1));
        tbl.push_back(mk("rd_w3_kept", 1, 0, 32'h0C, 0, -1, 0, 0, -1,
                         32'h12345678, 2'b10, 1, 1));
        tbl.push_back(mk("inj_in_ack", 1, 0, 32'h10, 0, -1, 0, 0, 2,
                         32'hCAFEF00D, 2'b10, 1, 1));

        foreach (tbl[i]) begin
            xact(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ld_at,
                 tbl[i].la, tbl[i].ldd, tbl[i].inj_at, 3,
                 acks, ack_c, kind, ack_busy, pre_ok);
            check({tbl[i].name, "/idle_before"}, 32'(pre_ok), 32'd1);
            check({tbl[i].name, "/acks"}, 32'(acks), 32'd1);
            check({tbl[i].name, "/ack_cycle"}, 32'(ack_c), 32'd2);
            check({tbl[i].name, "/kind"}, 32'(kind), 32'(tbl[i].kind));
            check({tbl[i].name, "/busy_ack"}, 32'(ack_busy), 32'd1);
            check({tbl[i].name, "/rdata"}, rdata, tbl[i].rdata);
            check({tbl[i].name, "/addr_err"}, 32'(addr_err), 32'(tbl[i].aerr));
            check({tbl[i].name, "/proto_err"}, 32'(proto_err), 32'(tbl[i].perr));
        end

        // Reset during the WAIT of a write to word 8.
        rd_req = 1'b0; wr_req = 1'b1; addr = 32'h20; wdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        wr_req = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_mid");
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (rd_ack || wr_ack) n++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd_ack || wr_ack) n++;
        end
        check("rst_mid/no_ack", 32'(n), 32'd0);
        @(posedge clk); #1;
        xact(1, 0, 32'h20, 0, -1, 0, 0, -1, 0,
             acks, ack_c, kind, ack_busy, pre_ok);
        check("rst_mid/w8_kept", rdata, 32'h88888888);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            lat = s ? 1 : 2;
            reset = 1'b1;
            #3 reset = 1'b0;
            check_reset_vals($sformatf("rnd_reset_L%0d", lat));
            @(posedge clk); #1;
            for (int i = 0; i < DEPTH; i++) begin
                mm[i] = $urandom;
                load(8'(i), mm[i]);
            end
            m_rdata = 32'h0; m_aerr = 1'b0; m_perr = 1'b0;
            for (int t = 0; t < 150; t++) begin
                logic        r, w, in;
                logic [29:0] idx;
                logic [31:0] a, d, ldd;
                logic [7:0]  la;
                int          k, ld_at, inj_at;
                string       tag;
                r = 1'($urandom_range(0, 1));
                w = !r;
                if ($urandom_range(0, 9) == 0) begin r = 1'b1; w = 1'b1; end
                k = $urandom_range(0, 9);
                if (k == 0) idx = 30'($urandom_range(256, 1023));
                else if (k == 1) idx = 30'($urandom);
                else idx = 30'($urandom_range(0, 15));
                a = {idx, 2'($urandom)};
                d = $urandom;
                in = idx < 30'(DEPTH);
                la = $urandom_range(0, 1) ? idx[7:0] : 8'($urandom_range(0, 15));
                ldd = $urandom;
                k = $urandom_range(0, 3);
                ld_at = (k == 0) ? lat - 1 :
                        (k == 1) ? int'($urandom_range(0, lat)) : -1;
                inj_at = ($urandom_range(0, 7) == 0) ?
                         int'($urandom_range(0, lat)) : -1;

                xact(r, w, a, d, ld_at, la, ldd, inj_at, 0,
                     acks, ack_c, kind, ack_busy, pre_ok);

                // The loader lands at edge ld_at+1; the request commits at
                // edge lat. A same-edge loader write is seen after the commit.
                if (ld_at >= 0 && ld_at + 1 < lat) mm[la] = ldd;
                if (r) m_rdata = in ? mm[idx[7:0]] : DEAD;
                else if (in) mm[idx[7:0]] = d;
                if (ld_at >= 0 && ld_at + 1 >= lat) mm[la] = ldd;
                if (!in) m_aerr = 1'b1;
                if ((r && w) || inj_at >= 0) m_perr = 1'b1;

                tag = $sformatf("rnd_L%0d_%0d", lat, t);
                check({tag, "/idle_before"}, 32'(pre_ok), 32'd1);
                check({tag, "/acks"}, 32'(acks), 32'd1);
                check({tag, "/ack_cycle"}, 32'(ack_c), 32'(lat));
                check({tag, "/kind"}, 32'(kind), r ? 32'd2 : 32'd1);
                check({tag, "/rdata"}, rdata, m_rdata);
                check({tag, "/addr_err"}, 32'(addr_err), 32'(m_aerr));
                check({tag, "/proto_err"}, 32'(proto_err), 32'(m_perr));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
